conv_weight_pingpong_buffer: RTL
================================

// Module: conv_weight_pingpong_buffer
// PURPOSE
// Parametrised, writable successor to the fixed weight ROM feeding the conv array. It holds
// KERNEL_NUM kernels (KERNEL_SIZE^2 weights + 1 bias each) in two banks. The active bank
// streams one kernel in step with the conv controller's current_state. The shadow bank is
// refilled from the loader over a valid/ready port, then swapped in without stalling the array.
// PARAMETERS
// DATA_WIDTH   32  weight/bias word width
// KERNEL_SIZE  3   kernel edge; W = KERNEL_SIZE*KERNEL_SIZE+1 words per kernel (weights, then bias)
// KERNEL_NUM   4   kernels per bank; DEPTH = KERNEL_NUM*W words per bank
// KSEL_WIDTH   2   width of i_kernel_sel, >= clog2(KERNEL_NUM)
// PORTS
// clk            in   1           rising-edge clock
// rst            in   1           asynchronous, active-high reset
// current_state  in   3           conv controller state: INIT=0 PRELOAD=1 ROW_0=2 ROW_1=3 ROW_2=4 BIAS=5 LOAD=6 IDLE=7
// i_kernel_sel   in   KSEL_WIDTH  kernel index to stream; sampled only in PRELOAD/LOAD
// i_wr_valid     in   1           loader word valid
// i_wr_data      in   DATA_WIDTH  loader word, sequential order: kernel 0 word 0 .. kernel N-1 word W-1
// o_wr_ready     out  1           shadow bank accepting writes
// i_swap         in   1           request to exchange active and shadow banks
// o_swap_ack     out  1           one-cycle pulse, swap performed
// o_shadow_full  out  1           shadow bank holds DEPTH words
// o_active_bank  out  1           index of the bank being read
// o_weight       out  DATA_WIDTH  registered weight/bias to the array
// o_weight_valid out  1           o_weight carries a stored word
// BEHAVIOUR
// - Reset (async, immediate): o_weight=0, o_weight_valid=0, o_active_bank=0, o_shadow_full=0,
//   o_swap_ack=0, rd_ptr=0, wr_ptr=0, ksel_q=0. o_wr_ready=1 once rst deasserts. Memory contents are not reset.
// - Emit states = ROW_0, ROW_1, ROW_2, BIAS. Storage is async-read; the output is registered.
// - Read: in an emit state, at the edge, o_weight <= mem[active][ksel_q*W + rd_ptr], o_weight_valid<=1,
//   and rd_ptr <= (rd_ptr==W-1) ? 0 : rd_ptr+1.
//   Latency is one cycle: the first emit cycle's edge presents word 0.
// - If ksel_q >= KERNEL_NUM in an emit state: o_weight <= 0, o_weight_valid <= 1, rd_ptr still advances.
// - In PRELOAD/LOAD: rd_ptr <= 0, ksel_q <= i_kernel_sel, o_weight <= 0, o_weight_valid <= 0.
// - In INIT/IDLE: rd_ptr holds, o_weight <= 0, o_weight_valid <= 0.
// - Write: o_wr_ready = !o_shadow_full. On i_wr_valid && o_wr_ready: mem[!active][wr_ptr] <= i_wr_data,
//   wr_ptr++. The write at wr_ptr==DEPTH-1 sets o_shadow_full=1 and wraps wr_ptr to 0.
//   Writes never touch the active bank. i_wr_valid with ready low is ignored; the loader must hold the word.
// - Swap is accepted when i_swap && o_shadow_full && current_state not an emit state. Next edge:
//   o_active_bank toggles, o_shadow_full <= 0, rd_ptr <= 0, wr_ptr <= 0, o_swap_ack <= 1 for one cycle.
//   A request failing any condition is dropped (no ack); the requester retries.
// - Swap and write cannot coincide: a swap needs full, and full forces ready low.
// - A swap in PRELOAD/LOAD also samples i_kernel_sel in that cycle. The next emit reads the new bank.
// - Reset mid-stream or mid-fill abandons both. The shadow bank is treated as empty; the partial data is unused.
// - Width rules: read index ksel_q*W+rd_ptr and wr_ptr are sized clog2(DEPTH); no arithmetic on data.
// TESTING
// - Reset, fill shadow with DEPTH words 0x100+i, then swap in IDLE -> ack pulse, active=1, full=0, ready=1.
// - Kernel select: select kernel 2 in PRELOAD (K=3,N=4), then ROW_0 x3, ROW_1 x3, ROW_2 x3, BIAS x1 ->
//   outputs 0x114..0x11D, valid high, one cycle after each state.
// - Wrap: hold BIAS for 12 cycles after 9 row words -> word index runs 9, 0, 1, ... (wrap at W-1=9).
// - Swap blocked: i_swap during ROW_1 with full=1 -> no ack, bank unchanged. Retry in LOAD -> ack.
// - Backpressure: keep i_wr_valid high past DEPTH words -> exactly DEPTH accepted, ready low, active bank
//   stream unchanged.
// - Invalid select and reset: ksel=5 (N=4) -> o_weight=0, valid=1. Assert rst mid-ROW_2 -> outputs 0
//   immediately, active=0, full=0.

Source files
------------

// File: rtl/conv_weight_pingpong_buffer.sv
// Two-bank weight store for the conv array: the active bank streams one kernel per conv pass
// while the loader refills the shadow bank, which is then swapped in between passes.
module conv_weight_pingpong_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int KERNEL_NUM  = 4,
    parameter int KSEL_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            current_state,
    input  logic [KSEL_WIDTH-1:0] i_kernel_sel,
    input  logic                  i_wr_valid,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_ready,
    input  logic                  i_swap,
    output logic                  o_swap_ack,
    output logic                  o_shadow_full,
    output logic                  o_active_bank,
    output logic [DATA_WIDTH-1:0] o_weight,
    output logic                  o_weight_valid
);
    localparam int W     = KERNEL_SIZE * KERNEL_SIZE + 1;
    localparam int DEPTH = KERNEL_NUM * W;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] ST_PRELOAD = 3'd1;
    localparam logic [2:0] ST_ROW_0   = 3'd2;
    localparam logic [2:0] ST_BIAS    = 3'd5;
    localparam logic [2:0] ST_LOAD    = 3'd6;

    logic [DATA_WIDTH-1:0] mem [2][DEPTH];

    logic [DATA_WIDTH-1:0] weight_q, weight_d;
    logic                  weight_valid_q, weight_valid_d;
    logic                  active_q, active_d;
    logic                  full_q, full_d;
    logic                  ack_q, ack_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [KSEL_WIDTH-1:0] ksel_q, ksel_d;

    logic          emit, sel_state, wr_en, swap_ok, ksel_ok;
    logic [AW-1:0] rd_idx;

    assign emit      = (current_state >= ST_ROW_0) && (current_state <= ST_BIAS);
    assign sel_state = (current_state == ST_PRELOAD) || (current_state == ST_LOAD);
    assign ksel_ok   = int'(ksel_q) < KERNEL_NUM;
    assign rd_idx    = AW'(ksel_q) * AW'(W) + rd_ptr_q;
    assign o_wr_ready = !full_q && !rst;
    assign wr_en     = i_wr_valid && o_wr_ready;
    // full already blocks writes, so a swap can never race a write into the same bank
    assign swap_ok   = i_swap && full_q && !emit;

    always_comb begin
        weight_d       = '0;
        weight_valid_d = 1'b0;
        active_d       = active_q;
        full_d         = full_q;
        ack_d          = 1'b0;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        ksel_d         = ksel_q;

        if (emit) begin
            weight_d       = ksel_ok ? mem[active_q][rd_idx] : '0;
            weight_valid_d = 1'b1;
            rd_ptr_d       = (rd_ptr_q == AW'(W - 1)) ? '0 : rd_ptr_q + 1'b1;
        end else if (sel_state) begin
            rd_ptr_d = '0;
            ksel_d   = i_kernel_sel;
        end

        if (wr_en) begin
            if (wr_ptr_q == AW'(DEPTH - 1)) begin
                wr_ptr_d = '0;
                full_d   = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end

        if (swap_ok) begin
            active_d = !active_q;
            full_d   = 1'b0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            ack_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight_q       <= '0;
            weight_valid_q <= 1'b0;
            active_q       <= 1'b0;
            full_q         <= 1'b0;
            ack_q          <= 1'b0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            ksel_q         <= '0;
        end else begin
            weight_q       <= weight_d;
            weight_valid_q <= weight_valid_d;
            active_q       <= active_d;
            full_q         <= full_d;
            ack_q          <= ack_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            ksel_q         <= ksel_d;
        end
    end

    // Storage is not reset; only the shadow bank is ever written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[!active_q][wr_ptr_q] <= i_wr_data;
    end

    assign o_weight       = weight_q;
    assign o_weight_valid = weight_valid_q;
    assign o_active_bank  = active_q;
    assign o_shadow_full  = full_q;
    assign o_swap_ack     = ack_q;
endmodule
